// File: rtl/vreg_file_scoreboard.sv
// Vector register file: element-masked multi-port writes (highest port wins), write-first bypassed reads, busy scoreboard.
// Latency: writes and busy updates commit at the clock edge; read data is registered, valid one cycle after request.
// Backpressure: none; every request is accepted each cycle and hazards are only reported through o_busy.
module vreg_file_scoreboard #(
    parameter int REG_LEN   = 128,
    parameter int NUM_REGS  = 32,
    parameter int ELEM_SIZE = 8,
    parameter int NUM_RD    = 3,
    parameter int NUM_WR    = 2,
    parameter int ZERO_REG0 = 1,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int NUM_EL    = REG_LEN / ELEM_SIZE
) (
    input  logic                                clk,
    input  logic                                nreset,
    input  logic [NUM_RD-1:0]                   i_rd_req,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]       i_rd_addr,
    input  logic [NUM_RD-1:0][NUM_EL-1:0]       i_rd_mask,
    output logic [NUM_RD-1:0]                   o_rd_valid,
    output logic [NUM_RD-1:0][REG_LEN-1:0]      o_rd_data,
    input  logic [NUM_WR-1:0][NUM_EL-1:0]       i_wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]       i_wr_addr,
    input  logic [NUM_WR-1:0][REG_LEN-1:0]      i_wr_data,
    input  logic [NUM_WR-1:0]                   i_wr_last,
    input  logic                                i_rsv_req,
    input  logic [ADDR_W-1:0]                   i_rsv_addr,
    output logic [NUM_REGS-1:0]                 o_busy
);

    logic [REG_LEN-1:0]                r_mem [NUM_REGS];
    logic [NUM_RD-1:0]                 r_rd_valid;
    logic [NUM_RD-1:0][REG_LEN-1:0]    r_rd_data;
    logic [NUM_REGS-1:0]               r_busy;

    logic [NUM_WR-1:0]                 w_wr_ok;
    logic [NUM_RD-1:0][REG_LEN-1:0]    w_rd_word;
    logic [NUM_REGS-1:0]               w_set;
    logic [NUM_REGS-1:0]               w_clr;
    logic [NUM_REGS-1:0]               w_busy_nxt;

    // A write port is live unless it targets the hardwired-zero register.
    always_comb begin
        w_wr_ok = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            w_wr_ok[p] = (ZERO_REG0 == 0) || (i_wr_addr[p] != '0);
        end
    end

    // Later ports overwrite earlier ones element by element, giving highest-index priority.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_mem[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_ok[p]) begin
                    for (int e = 0; e < NUM_EL; e++) begin
                        if (i_wr_en[p][e]) begin
                            r_mem[i_wr_addr[p]][e*ELEM_SIZE +: ELEM_SIZE] <= i_wr_data[p][e*ELEM_SIZE +: ELEM_SIZE];
                        end
                    end
                end
            end
        end
    end

    // Read path sees the same-cycle write data, applied in the same port order as the array update.
    always_comb begin
        w_rd_word = '0;
        for (int q = 0; q < NUM_RD; q++) begin
            w_rd_word[q] = r_mem[i_rd_addr[q]];
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wr_ok[p] && (i_wr_addr[p] == i_rd_addr[q])) begin
                    for (int e = 0; e < NUM_EL; e++) begin
                        if (i_wr_en[p][e]) begin
                            w_rd_word[q][e*ELEM_SIZE +: ELEM_SIZE] = i_wr_data[p][e*ELEM_SIZE +: ELEM_SIZE];
                        end
                    end
                end
            end
            for (int e = 0; e < NUM_EL; e++) begin
                if (!i_rd_mask[q][e]) begin
                    w_rd_word[q][e*ELEM_SIZE +: ELEM_SIZE] = '0;
                end
            end
            if ((ZERO_REG0 != 0) && (i_rd_addr[q] == '0)) begin
                w_rd_word[q] = '0;
            end
        end
    end

    // Data only updates on a request so the last result is held while idle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= i_rd_req;
            for (int q = 0; q < NUM_RD; q++) begin
                if (i_rd_req[q]) begin
                    r_rd_data[q] <= w_rd_word[q];
                end
            end
        end
    end

    // Set is applied after clear so a reservation on a retiring register keeps it busy.
    always_comb begin
        w_clr = '0;
        w_set = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (i_wr_last[p]) begin
                w_clr[i_wr_addr[p]] = 1'b1;
            end
        end
        if (i_rsv_req) begin
            w_set[i_rsv_addr] = 1'b1;
        end
        w_busy_nxt = (r_busy & ~w_clr) | w_set;
        if (ZERO_REG0 != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_busy     = r_busy;

endmodule

// File: doc/vreg_file_scoreboard.md
Name: vreg_file_scoreboard

Overview:
Parametrised vector register file with per-element write masks, multiple write ports with fixed priority, and registered read ports with write-first bypass. It also keeps a per-register busy scoreboard that the issue stage uses to detect hazards on in-flight destinations. The block sits between the vector decode/issue stage and the lane ALUs, and serves as the next-generation vector register storage.

Parameters:
REG_LEN, 128, bits per vector register
NUM_REGS, 32, number of vector registers
ELEM_SIZE, 8, bits per element (write/read mask granule); REG_LEN must be a multiple of it
NUM_RD, 3, number of read ports
NUM_WR, 2, number of write ports
ZERO_REG0, 1, 1 = register 0 reads as zero and ignores writes and reservations
ADDR_W, $clog2(NUM_REGS), register address width (derived)
NUM_EL, REG_LEN/ELEM_SIZE, elements per register (derived)

Ports:
clk  in  1  clock, all state on rising edge
nreset  in  1  asynchronous active-low reset
rd_req  in  [NUM_RD]  read request per port
rd_addr  in  [NUM_RD][ADDR_W]  read register address
rd_mask  in  [NUM_RD][NUM_EL]  per-element read enable
rd_valid  out  [NUM_RD]  read data valid, one cycle after rd_req
rd_data  out  [NUM_RD][REG_LEN]  registered read data
wr_en  in  [NUM_WR][NUM_EL]  per-element write enable
wr_addr  in  [NUM_WR][ADDR_W]  write register address
wr_data  in  [NUM_WR][REG_LEN]  write data
wr_last  in  [NUM_WR]  final write of the instruction; clears busy[wr_addr]
rsv_req  in  1  reserve destination register
rsv_addr  in  ADDR_W  register to mark busy
busy  out  NUM_REGS  scoreboard, 1 = write pending

Behaviour:
- Reset (async, nreset=0): all registers = 0, rd_valid = 0, rd_data = 0, busy = 0. Deassertion takes effect at the next clk edge. Reset mid-operation discards all pending reads and reservations.
- Writes: element e of register wr_addr[p] takes wr_data[p][e*ELEM_SIZE +: ELEM_SIZE] at posedge when wr_en[p][e]=1. Unmasked elements hold their value.
- Write conflicts: if several ports target the same register and element in one cycle, the highest-index port wins. Non-overlapping elements from different ports all commit.
- Register 0 with ZERO_REG0=1: writes are dropped, reads return 0, rsv/wr_last on address 0 are ignored and busy[0] stays 0.
- Read latency is 1 cycle. rd_req/rd_addr/rd_mask are sampled at posedge N; rd_valid=1 and rd_data hold the result during cycle N+1. rd_valid=0 on any cycle after a cycle with no request.
- When rd_valid=0, rd_data holds its previous value; the bench only checks it when valid.
- Masked-off read elements (rd_mask bit 0) return 0.
- Bypass (write-first): an element written in the same cycle a read samples it returns the new write data (after port priority), not the old value.
- Any number of read ports may read the same register with no stall.
- Scoreboard:
  - rsv_req sets busy[rsv_addr] at posedge.
  - Any wr_last[p]=1 with nonzero wr_en[p] or not clears busy[wr_addr[p]] at posedge.
  - Set and clear on the same register in the same cycle: set wins, so busy stays 1 (back-to-back reuse).
  - Reserving an already-busy register keeps it 1. Clearing a non-busy register is a no-op.
- The block performs no hazard stalling; it only reports busy.

Test Plan:
- Reset then read: assert nreset=0 mid-run, release, rd_req[0]=1 addr 5 mask all-ones -> next cycle rd_valid[0]=1, rd_data[0]=0, busy=0.
- Masked write/read: write reg 3, wr_en[0]=16'h00F0, data 128'h0F0E..00 -> read reg 3 with mask all-ones returns bytes 4-7 = 04..07 and other bytes 0. Reading with mask 16'h0010 returns only byte 4 = 8'h04.
- Port priority: same cycle, port0 writes reg 7 byte0=8'hAA and port1 writes reg 7 bytes0-1=8'hBB,8'hCC -> reg 7 byte0=BB, byte1=CC.
- Bypass: write reg 9 all bytes 8'h55 and read reg 9 on ports 0-2 in the same cycle -> all three rd_data = {16{8'h55}} next cycle.
- Register 0: write reg 0 with 8'hFF all bytes, then rsv_req addr 0 -> read reg 0 returns 0 and busy[0]=0.
- Scoreboard: rsv reg 4 -> busy[4]=1. Next cycle wr_last[1]=1 addr 4 together with rsv_req addr 4 -> busy[4] stays 1. The following wr_last alone -> busy[4]=0.
